// File: rtl/maze_pkg.sv
// Shared constants for the maze pixel pipeline: colour codes ({B,G,R})
// and the default maze/tile geometry.
package maze_pkg;

   localparam int MAZE_W_DEFAULT = 48;
   localparam int TILE_W_DEFAULT = 40;
   localparam int TILE_H_DEFAULT = 30;

   localparam logic [11:0] COL_PLAYER = 12'h0FF;
   localparam logic [11:0] COL_EXIT   = 12'h00F;
   localparam logic [11:0] COL_WALL   = 12'h996;
   localparam logic [11:0] COL_BLANK  = 12'h000;

endpackage

// File: rtl/maze_sync_delay.sv
// Fixed-depth shift register used to keep sync/enable and cell-address
// side information aligned with the ROM read latency.
module maze_sync_delay #(
   parameter int               DEPTH   = 3,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             div_clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   // Shift one stage per clock; reset loads the inactive value everywhere
   always_ff @(posedge div_clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
      end else begin
         pipe_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/maze_pixel_pipe.sv
// Pixel pipeline: raster -> maze/tile ROM addresses -> 12-bit colour.
// Stage 1 registers the addresses, the ROM registers its data, and the
// colour stage registers RGB together with the last sync delay stage.
// Optional feature: define PLAYER_BLINK_EN to blink the player marker
// with frame_cnt[5] (64-frame period).
module maze_pixel_pipe
   import maze_pkg::*;
#(
   parameter int MAZE_W   = MAZE_W_DEFAULT,
   parameter int TILE_W   = TILE_W_DEFAULT,
   parameter int TILE_H   = TILE_H_DEFAULT,
   parameter int VIEW_MAX = 32,
   parameter int MARGIN   = 7,
   parameter int END_ADDR = 2110
) (
   input  logic        div_clk,
   input  logic        rst,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic        in_de,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  player_x,
   input  logic [9:0]  player_y,
   output logic [11:0] maze_addr,
   input  logic        maze_q,
   output logic [10:0] tile_addr,
   input  logic [11:0] tile_q,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  R,
   output logic [3:0]  G,
   output logic [3:0]  B
);

   // Saturate (pos - MARGIN) into 0..VIEW_MAX; bit 9 set means it went negative
   function automatic logic [9:0] clamp_view(input logic [9:0] pos);
      logic [9:0] diff;
      diff = pos - 10'(MARGIN);
      if (diff[9])                      clamp_view = '0;
      else if (diff > 10'(VIEW_MAX))    clamp_view = 10'(VIEW_MAX);
      else                              clamp_view = diff;
   endfunction

   logic        vs_prev_q;
   logic [9:0]  cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
   logic [5:0]  frame_cnt_q, frame_cnt_d;
   logic [5:0]  tx_q, tx_d;
   logic [4:0]  ty_q, ty_d;
   logic [9:0]  col_q, col_d, row_q, row_d;
   logic [11:0] cell_x, cell_y, maze_addr_d, maze_addr_q;
   logic [10:0] tile_addr_d, tile_addr_q;
   logic [2:0]  sync_p1;
   logic [11:0] cell_p1;
   logic [11:0] player_addr;
   logic        show_player;
   logic [11:0] rgb_d, rgb_q;
   logic        hsync_q, vsync_q;

   // Cursor is latched once per frame on the vsync falling edge
   always_comb begin
      cursor_x_d  = cursor_x_q;
      cursor_y_d  = cursor_y_q;
      frame_cnt_d = frame_cnt_q;
      if (vs_prev_q && !in_vsync) begin
         cursor_x_d  = clamp_view(player_x);
         cursor_y_d  = clamp_view(player_y);
         frame_cnt_d = frame_cnt_q + 6'd1;
      end
   end

   // Frame-level state: vsync history, viewport cursor, frame counter
   always_ff @(posedge div_clk) begin
      if (rst) begin
         vs_prev_q   <= 1'b1;
         cursor_x_q  <= '0;
         cursor_y_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         vs_prev_q   <= in_vsync;
         cursor_x_q  <= cursor_x_d;
         cursor_y_q  <= cursor_y_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Tile texel/cell counters for the current pixel (x==0 restarts a line)
   always_comb begin
      tx_d  = tx_q;
      col_d = col_q;
      ty_d  = ty_q;
      row_d = row_q;
      if (x == '0) begin
         tx_d  = '0;
         col_d = '0;
         if (y == '0) begin
            ty_d  = '0;
            row_d = '0;
         end else if (ty_q == 5'(TILE_H - 1)) begin
            ty_d  = '0;
            row_d = row_q + 10'd1;
         end else begin
            ty_d  = ty_q + 5'd1;
         end
      end else if (tx_q == 6'(TILE_W - 1)) begin
         tx_d  = '0;
         col_d = col_q + 10'd1;
      end else begin
         tx_d  = tx_q + 6'd1;
      end
   end

   // Shift-add address arithmetic: x48 = <<5 + <<4, x40 = <<5 + <<3
   always_comb begin
      cell_x      = 12'(cursor_x_q) + 12'(col_d);
      cell_y      = 12'(cursor_y_q) + 12'(row_d);
      maze_addr_d = '0;
      tile_addr_d = '0;
      if (in_de) begin
         maze_addr_d = cell_x + (cell_y << 5) + (cell_y << 4);
         tile_addr_d = 11'(tx_d) + (11'(ty_d) << 5) + (11'(ty_d) << 3);
      end
   end

   // ---- stage 1: counters and ROM addresses ----
   always_ff @(posedge div_clk) begin
      if (rst) begin
         tx_q        <= '0;
         ty_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
         maze_addr_q <= '0;
         tile_addr_q <= '0;
      end else begin
         tx_q        <= tx_d;
         ty_q        <= ty_d;
         col_q       <= col_d;
         row_q       <= row_d;
         maze_addr_q <= maze_addr_d;
         tile_addr_q <= tile_addr_d;
      end
   end

   assign maze_addr = maze_addr_q;
   assign tile_addr = tile_addr_q;

   // ---- stage 2: ROM data; side information delayed to match ----
   maze_sync_delay #(.DEPTH(2), .WIDTH(3), .RST_VAL(3'b110)) u_sync_dly (
      .div_clk (div_clk),
      .rst     (rst),
      .din_i   ({in_hsync, in_vsync, in_de}),
      .dout_o  (sync_p1)
   );

   maze_sync_delay #(.DEPTH(1), .WIDTH(12), .RST_VAL(12'h000)) u_cell_dly (
      .div_clk (div_clk),
      .rst     (rst),
      .din_i   (maze_addr_q),
      .dout_o  (cell_p1)
   );

   assign player_addr = 12'(player_x) + 12'(player_y * MAZE_W);

`ifdef PLAYER_BLINK_EN
   assign show_player = ~frame_cnt_q[5];
`else
   assign show_player = 1'b1;
`endif

   // Colour priority: blank, player, exit, wall, tile texel
   always_comb begin
      rgb_d = COL_BLANK;
      if (sync_p1[0]) begin
         if (show_player && (cell_p1 == player_addr)) rgb_d = COL_PLAYER;
         else if (cell_p1 == 12'(END_ADDR))           rgb_d = COL_EXIT;
         else if (maze_q)                             rgb_d = COL_WALL;
         else                                         rgb_d = tile_q;
      end
   end

   // ---- stage 3: colour and final sync delay stage ----
   always_ff @(posedge div_clk) begin
      if (rst) begin
         rgb_q   <= COL_BLANK;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= sync_p1[2];
         vsync_q <= sync_p1[1];
      end
   end

   assign hsync = hsync_q;
   assign vsync = vsync_q;
   assign R     = rgb_q[3:0];
   assign G     = rgb_q[7:4];
   assign B     = rgb_q[11:8];

endmodule
